// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an ARRAY_SIZE x ARRAY_SIZE weight-stationary PE
// array. A start pulse runs three phases in order:
//   W_LOAD  - one weight row is read per cycle, and the matching one-hot row
//             enable is raised in the following cycle.
//   COMPUTE - ifmap vectors are streamed, one per cycle in which the buffer
//             has data.
//   DRAIN   - 2*ARRAY_SIZE cycles during which the skew pipeline empties.
// Each ifmap read is followed by a diagonal wave of enables: the ifmap/psum
// enables at the array edge, then the ofmap valids at the bottom edge.
//
// Optional feature: define SYSTOLIC_CTRL_WEIGHT_REUSE_EN to add keep_weight_i.
// When keep_weight_i is sampled high with start, W_LOAD is skipped and the
// weights already held in the array are reused.
module systolic_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  num_vec_i,
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    input  logic                  keep_weight_i,
`endif
    input  logic                  ifmap_valid_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  weight_rd_en_o,
    output logic [ADDR_WIDTH-1:0] weight_addr_o,
    output logic                  ifmap_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ifmap_addr_o,
    output logic [ARRAY_SIZE-1:0] weight_en_o,
    output logic [ARRAY_SIZE-1:0] ifmap_en_o,
    output logic [ARRAY_SIZE-1:0] psum_en_o,
    output logic [ARRAY_SIZE-1:0] ofmap_valid_o
);

    localparam int DRAIN_CYCLES = 2 * ARRAY_SIZE;
    localparam int DW           = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WK           = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    // A single chain serves every skewed enable. Tap k carries the read
    // strobe delayed k+1 cycles: the low half feeds the row/column edge
    // enables and the high half feeds the bottom-edge ofmap valids.
    localparam int PIPE         = 2 * ARRAY_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  num_vec_q;
    logic [CNT_WIDTH-1:0]  vcnt_q;
    logic [CNT_WIDTH-1:0]  vcnt_d;
    logic [WK-1:0]         wrow_q;
    logic [DW-1:0]         dcnt_q;
    logic                  weight_rd_en_q;
    logic [ARRAY_SIZE-1:0] weight_en_q;
    logic [ARRAY_SIZE-1:0] weight_en_d;
    logic [PIPE-1:0]       vld_pipe_q;
    logic [PIPE-1:0]       vld_pipe_d;
    logic                  rd_strobe;
    logic                  skip_wload;

`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    assign skip_wload = keep_weight_i;
`else
    assign skip_wload = 1'b0;
`endif

    // The ifmap read is qualified by the buffer's same-cycle valid. A cycle
    // without data leaves the address unchanged and sends a bubble into the
    // skew chain.
    assign rd_strobe = (state_q == S_COMPUTE) && ifmap_valid_i;
    assign vcnt_d    = vcnt_q + 1'b1;

    // Next-state values for the enable pipelines.
    always_comb begin
        vld_pipe_d  = {vld_pipe_q[PIPE-2:0], rd_strobe};
        weight_en_d = '0;
        if (weight_rd_en_q)
            weight_en_d = ARRAY_SIZE'(1) << wrow_q;
    end

    // Phase sequencing: counters and the weight read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            num_vec_q      <= '0;
            vcnt_q         <= '0;
            wrow_q         <= '0;
            dcnt_q         <= '0;
            weight_rd_en_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        num_vec_q <= num_vec_i;
                        vcnt_q    <= '0;
                        wrow_q    <= '0;
                        dcnt_q    <= '0;
                        if (skip_wload) begin
                            state_q <= (num_vec_i == '0) ? S_DONE : S_COMPUTE;
                        end else begin
                            state_q        <= S_WLOAD;
                            weight_rd_en_q <= 1'b1;
                        end
                    end
                end
                S_WLOAD: begin
                    if (wrow_q == WK'(ARRAY_SIZE - 1)) begin
                        weight_rd_en_q <= 1'b0;
                        wrow_q         <= '0;
                        state_q        <= (num_vec_q == '0) ? S_DONE : S_COMPUTE;
                    end else begin
                        wrow_q <= wrow_q + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (rd_strobe) begin
                        vcnt_q <= vcnt_d;
                        if (vcnt_d == num_vec_q)
                            state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Long enough for the last read to reach the ofmap
                    // valid of the far column.
                    if (dcnt_q == DW'(DRAIN_CYCLES - 1))
                        state_q <= S_DONE;
                    else
                        dcnt_q <= dcnt_q + 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Registered enables: the weight row load and the skew chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_en_q <= '0;
            vld_pipe_q  <= '0;
        end else begin
            weight_en_q <= weight_en_d;
            vld_pipe_q  <= vld_pipe_d;
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign weight_rd_en_o = weight_rd_en_q;
    assign weight_addr_o  = ADDR_WIDTH'(wrow_q);
    assign ifmap_rd_en_o  = rd_strobe;
    assign ifmap_addr_o   = ADDR_WIDTH'(vcnt_q);
    assign weight_en_o    = weight_en_q;
    assign ifmap_en_o     = vld_pipe_q[ARRAY_SIZE-1:0];
    assign psum_en_o      = vld_pipe_q[ARRAY_SIZE-1:0];
    assign ofmap_valid_o  = vld_pipe_q[PIPE-1:ARRAY_SIZE];

endmodule
